led_scan_driver: RTL and testbench
==================================

Name: led_scan_driver

Overview:
- Consumes the 32-bit syscall-captured LED value and drives an 8-digit multiplexed, common-anode seven-segment display as hexadecimal.
- Snapshots the value once per scan frame so a frame never shows mixed old and new digits.
- Sits between the LED-data capture register and the board display pins.

Parameters:
- TICK_CYCLES, 100000: clk cycles each digit stays lit before the scan advances; legal range 2..2^20.
- BLANK_LZ, 1: when 1, leading-zero digits are blanked; when 0, all 8 digits are always lit.

Ports:
- clk  input  1  system clock, all state on rising edge.
- clr  input  1  reset, asynchronous, active-low: 0 resets all state immediately.
- leddata  input  32  value to display, 8 hex digits; digit i = leddata[4i+3:4i].
- an  output  8  anode enables, active-low; an[i] lights digit i (an[0] = rightmost).
- seg  output  7  segment cathodes, active-low; seg[0]=a … seg[6]=g.
- dp  output  1  decimal point, active-low; held 1 (off) always.
- frame_start  output  1  one-cycle pulse in the cycle after the snapshot loads.

Behaviour:
- Reset (clr=0): tick counter=0, idx=0, shadow=0, an=8'hFF, seg=7'h7F, dp=1, frame_start=0.
- Tick counter cnt: counts 0..TICK_CYCLES-1 and wraps to 0. tick = (cnt==TICK_CYCLES-1).
- Digit index idx, 3 bits: on tick, idx <= idx+1 mod 8 (7 wraps to 0).
- Snapshot shadow, 32 bits:
  - Loads leddata on tick with idx==7, i.e. in the same edge where idx wraps to 0.
  - Also loads on the first clock edge after clr deasserts (internal first flag).
  - leddata changes between loads are ignored.
- frame_start: registered; 1 for exactly the cycle following each shadow load, including the post-reset load.
- Outputs are registered, computed from the current idx and shadow. They change one cycle after idx or shadow changes.
- an: one-hot-low, an = ~(8'b1 << idx). Exception: all ones when digit idx is blanked.
- Blanking: digit i (i>0) is blanked iff BLANK_LZ==1 and shadow[31:4i]==0. Digit 0 is never blanked, so value 0 shows a single "0".
- seg: decoded nibble shadow[4idx+3:4idx], active-low gfedcba:
  - 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78
  - 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E
  - When the digit is blanked, seg=7F.
- Reset mid-frame: all state returns to its reset value asynchronously. The scan restarts at idx 0 with a fresh snapshot on the first edge after release.
- leddata changing in the same cycle as the snapshot load: the value sampled at that edge is used.
- No state other than cnt, idx, shadow, first flag and output registers.

Decomposition:
- Shared package:
  - SEG_BLANK = 7'h7F.
  - AN_OFF = 8'hFF.
  - NUM_DIGITS = 8.
  - The 16-entry hex-to-segment constant table.
- One sub-module: hex7seg_decode. Purely combinational; 4-bit nibble in, 7-bit active-low segments out; instantiated once, fed by the idx-selected nibble.

Test Plan:
- Reset/idle: hold clr=0, leddata=32'h12345678. Required: an=FF, seg=7F, dp=1, frame_start=0. Release clr. Required: frame_start pulses on cycle 2, shadow=12345678, an=FE, seg=00 ("8").
- Full scan, TICK_CYCLES=4, leddata=32'h89ABCDEF:
  - Required: each an value held 4 cycles, sequence FE,FD,FB,F7,EF,DF,BF,7F.
  - Required: seg sequence 0E,06,21,46,03,08,10,00.
  - Required: sequence repeats with a frame_start pulse every 32 cycles.
- Leading-zero blanking, BLANK_LZ=1, leddata=32'h00000A05:
  - Required: digits 0..2 lit with seg 12,40,08.
  - Required: digits 3..7 an=FF, seg=7F. Zero value shows only digit 0 = 40.
  - With BLANK_LZ=0: all 8 digits lit, upper digits seg=40.
- Snapshot coherence: change leddata from 32'h11111111 to 32'h22222222 while idx=3. Required: the remainder of the frame shows 79. New value 24 appears starting at idx 0 after the wrap, together with frame_start.
- Async reset mid-frame: assert clr=0 at idx=5 between clock edges. Required: an=FF, seg=7F immediately, without waiting for a clock edge. After release, the scan restarts at an=FE.

Source files
------------

// File: rtl/led_scan_driver_pkg.sv
// Shared constants for the multiplexed seven-segment LED scan driver.
package led_scan_driver_pkg;

  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned NIB_W      = 4;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned DATA_W     = NUM_DIGITS * NIB_W;

  localparam logic [SEG_W-1:0]      SEG_BLANK = 7'h7F;
  localparam logic [NUM_DIGITS-1:0] AN_OFF    = 8'hFF;

  // Active-low gfedcba patterns for hex digits 0..F.
  localparam logic [SEG_W-1:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/hex7seg_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
module hex7seg_decode
  import led_scan_driver_pkg::*;
(
  input  logic [NIB_W-1:0] nibble,
  output logic [SEG_W-1:0] seg_c
);

  assign seg_c = HEX_SEG[nibble];

endmodule

// File: rtl/led_scan_driver.sv
// Scans a per-frame snapshot of a 32-bit value across 8 common-anode hex digits.
module led_scan_driver
  import led_scan_driver_pkg::*;
#(
  parameter int unsigned TICK_CYCLES = 100000,
  parameter int unsigned BLANK_LZ    = 1
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [DATA_W-1:0]     leddata,
  output logic [NUM_DIGITS-1:0] an,
  output logic [SEG_W-1:0]      seg,
  output logic                  dp,
  output logic                  frame_start
);

  localparam int unsigned CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);

  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] shadow;
  logic              first;

  logic              tick_c;
  logic              load_c;
  logic [NIB_W-1:0]  nib_c;
  logic [DATA_W-1:0] upper_c;
  logic              blank_c;
  logic [SEG_W-1:0]  dec_seg_c;

  assign tick_c  = (cnt == CNT_W'(TICK_CYCLES - 1));
  assign load_c  = first | (tick_c & (idx == IDX_W'(NUM_DIGITS - 1)));
  assign nib_c   = shadow[{idx, 2'b00} +: NIB_W];
  assign upper_c = shadow >> {idx, 2'b00};
  // Digit 0 is never blanked so a zero value still shows a single "0".
  assign blank_c = (BLANK_LZ == 1) && (idx != '0) && (upper_c == '0);

  hex7seg_decode u_dec (
    .nibble (nib_c),
    .seg_c  (dec_seg_c)
  );

  // The load edge after reset leaves cnt at 0 so the first digit gets a full tick,
  // and frame_start lines up with the first displayed digit of each new snapshot.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cnt         <= '0;
      idx         <= '0;
      shadow      <= '0;
      first       <= 1'b1;
      an          <= AN_OFF;
      seg         <= SEG_BLANK;
      dp          <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      first       <= 1'b0;
      dp          <= 1'b1;
      frame_start <= !first && (idx == '0) && (cnt == '0);
      if (load_c) begin
        shadow <= leddata;
      end
      if (!first) begin
        cnt <= tick_c ? '0 : cnt + CNT_W'(1);
        if (tick_c) begin
          idx <= idx + IDX_W'(1);
        end
      end
      if (first || blank_c) begin
        an  <= AN_OFF;
        seg <= SEG_BLANK;
      end else begin
        an  <= ~(NUM_DIGITS'(1) << idx);
        seg <= dec_seg_c;
      end
    end
  end

endmodule

// File: tb/tb_led_scan_driver.sv
// Scoreboard bench for led_scan_driver: blanking and non-blanking instances side by side.
module tb_led_scan_driver;

  localparam int unsigned T     = 4;
  localparam int unsigned FRAME = 8 * T;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic [31:0] leddata = 32'h0;
  logic [7:0]  an_b, an_n;
  logic [6:0]  seg_b, seg_n;
  logic        dp_b, dp_n, fs_b, fs_n;

  led_scan_driver #(.TICK_CYCLES(T), .BLANK_LZ(1)) u_dut_b (
    .clk(clk), .clr(clr), .leddata(leddata),
    .an(an_b), .seg(seg_b), .dp(dp_b), .frame_start(fs_b)
  );

  led_scan_driver #(.TICK_CYCLES(T), .BLANK_LZ(0)) u_dut_n (
    .clk(clk), .clr(clr), .leddata(leddata),
    .an(an_n), .seg(seg_n), .dp(dp_n), .frame_start(fs_n)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] an_b;
    logic [6:0] seg_b;
    logic [7:0] an_n;
    logic [6:0] seg_n;
    logic       fs;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned k        = 0;
  logic [31:0] snap     = 32'h0;

  function automatic logic [6:0] hex_seg(input int unsigned v);
    case (v)
      0: return 7'h40;   1: return 7'h79;   2: return 7'h24;   3: return 7'h30;
      4: return 7'h19;   5: return 7'h12;   6: return 7'h02;   7: return 7'h78;
      8: return 7'h00;   9: return 7'h10;  10: return 7'h08;  11: return 7'h03;
      12: return 7'h46; 13: return 7'h21;  14: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  function automatic exp_t off_exp();
    exp_t e;
    e.an_b = 8'hFF; e.seg_b = 7'h7F; e.an_n = 8'hFF; e.seg_n = 7'h7F; e.fs = 1'b0;
    return e;
  endfunction

  // Display after the kk-th edge since release, using the snapshot s of the current frame.
  function automatic exp_t predict(input int unsigned kk, input logic [31:0] s);
    exp_t        e;
    int unsigned d;
    logic [31:0] upper;
    logic [7:0]  onehot;
    if (kk < 2) return off_exp();
    d      = ((kk - 2) / T) % 8;
    upper  = s >> (4 * d);
    onehot = 8'd1 << d;
    e.an_n  = ~onehot;
    e.seg_n = hex_seg(int'(upper & 32'hF));
    if (d > 0 && upper == 0) begin
      e.an_b = 8'hFF; e.seg_b = 7'h7F;
    end else begin
      e.an_b = e.an_n; e.seg_b = e.seg_n;
    end
    e.fs = ((kk - 2) % FRAME) == 0;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Reference model: one expectation per rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (!clr) begin
        k    = 0;
        snap = 32'h0;
        exp_q.push_back(off_exp());
      end else begin
        k++;
        e = predict(k, snap);
        if (k == 1 || ((k - 1) % FRAME) == 0) snap = leddata;
        exp_q.push_back(e);
      end
    end
  end

  // Monitor: compare DUT outputs against the queued expectation mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("an_blank",  32'(an_b),  32'(e.an_b));
        check("seg_blank", 32'(seg_b), 32'(e.seg_b));
        check("an_full",   32'(an_n),  32'(e.an_n));
        check("seg_full",  32'(seg_n), 32'(e.seg_n));
        check("frame_start", 32'({fs_b, fs_n}), 32'({e.fs, e.fs}));
        check("dp", 32'({dp_b, dp_n}), 32'h3);
      end
    end
  end

  task automatic wait_digit(input int unsigned d);
    for (int i = 0; i < int'(FRAME) + 4; i++) begin
      @(negedge clk);
      if (k >= 2 && ((k - 2) / T) % 8 == d) return;
    end
    n_checks++;
    n_fail++;
    $display("FAIL wait_digit: digit %0d not reached within bound", d);
  endtask

  task automatic run(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [31:0] v;
    leddata = 32'h12345678;
    clr     = 1'b0;
    run(3);
    check("reset_an",  32'(an_b),  32'hFF);
    check("reset_seg", 32'(seg_b), 32'h7F);
    check("reset_fs",  32'(fs_b),  32'h0);

    clr = 1'b1;
    run(2);
    leddata = 32'h89ABCDEF;
    run(3 * FRAME);

    leddata = 32'h00000A05;
    run(2 * FRAME);
    leddata = 32'h00000000;
    run(2 * FRAME);

    leddata = 32'h11111111;
    run(FRAME);
    wait_digit(3);
    leddata = 32'h22222222;
    run(2 * FRAME);

    // Asynchronous reset between edges while digit 5 is shown.
    wait_digit(5);
    #2 clr = 1'b0;
    #1;
    check("async_an",  32'({an_b, an_n}),   32'hFFFF);
    check("async_seg", 32'({seg_b, seg_n}), 32'h3FFF);
    check("async_fs",  32'({fs_b, fs_n}),   32'h0);
    run(2);
    leddata = 32'hDEADBEEF;
    clr = 1'b1;
    run(FRAME + 4);

    for (int i = 0; i < 25; i++) begin
      v = $urandom;
      v = v >> $urandom_range(0, 32);
      leddata = v;
      run($urandom_range(1, 40));
    end
    run(FRAME + 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
